chirp_sweep_gen: RTL and testbench

Parametrised linear-FM chirp generator. It is the next generation of the chirp top-level datapath.
- A phase accumulator is driven by a frequency word that ramps from f_start to f_stop in f_step increments, one step every dwell cycles.
- Three sweep modes: one-shot, repeat (sawtooth sweep), triangle (up/down).
- Outputs: square wave, multi-bit sawtooth phase, and sweep status for the TinyTapeout wrapper.

---
 rtl/chirp_pkg.sv | 19 +
 rtl/chirp_phase_acc.sv | 26 ++
 rtl/chirp_sweep_gen.sv | 159 +++++++++++++++
 tb/tb_chirp_sweep_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/chirp_pkg.sv
// Shared constants and types for the chirp sweep generator.
package chirp_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  // Mode 3 is reserved and behaves as a one-shot sweep.
  function automatic logic [1:0] mode_norm(input logic [1:0] m);
    return (m == 2'd3) ? MODE_ONESHOT : m;
  endfunction

endpackage

// File: rtl/chirp_phase_acc.sv
// Phase accumulator: adds the zero-extended frequency word every enabled cycle.
module chirp_phase_acc #(
  parameter int PHASE_W = 16,
  parameter int FREQ_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [FREQ_W-1:0]  freq,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phase_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase_reg <= '0;
    end else if (en) begin
      phase_reg <= phase_reg + PHASE_W'(freq);
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/chirp_sweep_gen.sv
// Linear-FM chirp generator: stepped frequency ramp driving a phase accumulator,
// with one-shot, sawtooth-repeat and triangle sweep modes.
module chirp_sweep_gen
  import chirp_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int FREQ_W  = 12,
  parameter int DWELL_W = 8,
  parameter int OUT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FREQ_W-1:0]  freq,
  output logic               sq_out,
  output logic [OUT_W-1:0]   wave_out,
  output logic               busy,
  output logic               done,
  output logic               sweep_wrap
);

  state_t             state_reg;
  logic [FREQ_W-1:0]  freq_reg;
  logic [FREQ_W-1:0]  start_l_reg;
  logic [FREQ_W-1:0]  stop_l_reg;
  logic [FREQ_W-1:0]  step_l_reg;
  logic [DWELL_W-1:0] dwell_l_reg;
  logic [DWELL_W-1:0] dwell_cnt_reg;
  logic [1:0]         mode_l_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               wrap_reg;

  logic               accept;
  logic               step_edge;
  logic               at_stop;
  logic               going_idle;
  logic [FREQ_W:0]    up_sum;
  logic [FREQ_W:0]    down_diff;
  logic [FREQ_W-1:0]  up_next;
  logic [FREQ_W-1:0]  down_next;
  logic [PHASE_W-1:0] phase;

  assign accept    = (state_reg == ST_IDLE) && start && !abort;
  assign step_edge = (dwell_cnt_reg == DWELL_W'(dwell_l_reg - DWELL_W'(1)));
  assign at_stop   = (freq_reg == stop_l_reg);

  // Ramp arithmetic carries one extra bit so neither direction can wrap.
  always_comb begin
    up_sum    = {1'b0, freq_reg} + {1'b0, step_l_reg};
    down_diff = {1'b0, freq_reg} - {1'b0, step_l_reg};
    up_next   = (up_sum > {1'b0, stop_l_reg}) ? stop_l_reg : up_sum[FREQ_W-1:0];
    down_next = (down_diff[FREQ_W] || (down_diff[FREQ_W-1:0] < start_l_reg))
                ? start_l_reg : down_diff[FREQ_W-1:0];
  end

  assign going_idle = busy_reg &&
                      (abort || (step_edge && (state_reg == ST_UP) && at_stop &&
                                 (mode_l_reg == MODE_ONESHOT)));

  chirp_phase_acc #(
    .PHASE_W(PHASE_W),
    .FREQ_W (FREQ_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clear(accept || going_idle),
    .en   (busy_reg),
    .freq (freq_reg),
    .phase(phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      freq_reg      <= '0;
      start_l_reg   <= '0;
      stop_l_reg    <= '0;
      step_l_reg    <= '0;
      dwell_l_reg   <= '0;
      dwell_cnt_reg <= '0;
      mode_l_reg    <= MODE_ONESHOT;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      wrap_reg <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (accept) begin
          start_l_reg   <= f_start;
          stop_l_reg    <= (f_stop > f_start) ? f_stop : f_start;
          step_l_reg    <= (f_step == '0) ? FREQ_W'(1) : f_step;
          dwell_l_reg   <= (dwell == '0) ? DWELL_W'(1) : dwell;
          mode_l_reg    <= mode_norm(mode);
          freq_reg      <= f_start;
          dwell_cnt_reg <= '0;
          state_reg     <= ST_UP;
          busy_reg      <= 1'b1;
        end
      end else if (abort) begin
        state_reg     <= ST_IDLE;
        freq_reg      <= '0;
        dwell_cnt_reg <= '0;
        busy_reg      <= 1'b0;
      end else if (!step_edge) begin
        dwell_cnt_reg <= dwell_cnt_reg + DWELL_W'(1);
      end else begin
        dwell_cnt_reg <= '0;
        if (state_reg == ST_UP) begin
          if (at_stop) begin
            case (mode_l_reg)
              MODE_REPEAT: begin
                freq_reg <= start_l_reg;
                wrap_reg <= 1'b1;
              end
              // Turnaround steps immediately so the endpoint is held only one dwell.
              MODE_TRIANGLE: begin
                state_reg <= ST_DOWN;
                freq_reg  <= down_next;
                wrap_reg  <= 1'b1;
              end
              default: begin
                state_reg <= ST_IDLE;
                freq_reg  <= '0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            endcase
          end else begin
            freq_reg <= up_next;
          end
        end else begin
          if (freq_reg == start_l_reg) begin
            state_reg <= ST_UP;
            freq_reg  <= up_next;
            wrap_reg  <= 1'b1;
          end else begin
            freq_reg <= down_next;
          end
        end
      end
    end
  end

  assign freq       = freq_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign sweep_wrap = wrap_reg;
  assign sq_out     = busy_reg & phase[PHASE_W-1];
  assign wave_out   = busy_reg ? phase[PHASE_W-1 -: OUT_W] : '0;

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Directed testbench for chirp_sweep_gen with hand-computed expectations.
module tb_chirp_sweep_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] f_start = '0;
  logic [11:0] f_stop = '0;
  logic [11:0] f_step = '0;
  logic [7:0]  dwell = '0;
  logic [11:0] freq;
  logic        sq_out;
  logic [3:0]  wave_out;
  logic        busy;
  logic        done;
  logic        sweep_wrap;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int phase_m = 0;

  chirp_sweep_gen #(
    .PHASE_W(16), .FREQ_W(12), .DWELL_W(8), .OUT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .freq(freq), .sq_out(sq_out), .wave_out(wave_out), .busy(busy),
    .done(done), .sweep_wrap(sweep_wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks every output, plus the accumulator against the bench's own phase model.
  task automatic check_state(input string tag, input int ef, input bit eb, input bit ed, input bit ew);
    logic [15:0] pm;
    pm = 16'(phase_m);
    chk({tag, " freq"}, 32'(freq), 32'(ef));
    chk({tag, " busy"}, 32'(busy), 32'(eb));
    chk({tag, " done"}, 32'(done), 32'(ed));
    chk({tag, " wrap"}, 32'(sweep_wrap), 32'(ew));
    chk({tag, " wave"}, 32'(wave_out), eb ? 32'(pm[15:12]) : 32'd0);
    chk({tag, " sq"}, 32'(sq_out), eb ? 32'(pm[15]) : 32'd0);
    if (eb) chk({tag, " phase"}, 32'(dut.u_acc.phase), 32'(pm));
    $display("%s: freq=%0d busy=%0b done=%0b wrap=%0b wave=%0d sq=%0b",
             tag, freq, busy, done, sweep_wrap, wave_out, sq_out);
  endtask

  task automatic launch(input logic [1:0] m, input int fs, input int fe, input int fst, input int dw);
    mode = m; f_start = 12'(fs); f_stop = 12'(fe); f_step = 12'(fst); dwell = 8'(dw);
    start = 1'b1;
    tick();
    start = 1'b0;
    phase_m = 0;
  endtask

  initial begin
    int e_os[8];
    int e_rp[3];
    int e_tr[4];
    e_os = '{16, 16, 32, 32, 48, 48, 64, 64};
    e_rp = '{8, 16, 24};
    e_tr = '{4, 8, 12, 8};

    // Reset state
    tick(); tick();
    check_state("reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check_state("idle", 0, 0, 0, 0);

    // One-shot sweep
    launch(2'd0, 16, 64, 16, 2);
    check_state("os0", e_os[0], 1, 0, 0);
    for (int i = 1; i < 8; i++) begin
      phase_m = (phase_m + e_os[i-1]) & 16'hFFFF;
      tick();
      check_state($sformatf("os%0d", i), e_os[i], 1, 0, 0);
    end
    tick();
    check_state("os_done", 0, 0, 1, 0);
    tick();
    check_state("os_after", 0, 0, 0, 0);

    // Repeat sweep: wrap on each 24->8 step, phase carried across
    launch(2'd1, 8, 24, 8, 1);
    check_state("rp0", 8, 1, 0, 0);
    for (int i = 1; i < 9; i++) begin
      phase_m = (phase_m + e_rp[(i-1)%3]) & 16'hFFFF;
      tick();
      check_state($sformatf("rp%0d", i), e_rp[i%3], 1, 0, (i % 3) == 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_state("rp_abort", 0, 0, 0, 0);

    // Triangle sweep with start held high mid-sweep using a different config
    launch(2'd2, 4, 12, 4, 1);
    check_state("tr0", 4, 1, 0, 0);
    for (int i = 1; i < 10; i++) begin
      if (i == 2) begin
        start = 1'b1; mode = 2'd0; f_start = 12'd100; f_stop = 12'd200; f_step = 12'd7; dwell = 8'd5;
      end
      if (i == 6) start = 1'b0;
      phase_m = (phase_m + e_tr[(i-1)%4]) & 16'hFFFF;
      tick();
      check_state($sformatf("tr%0d", i), e_tr[i%4], 1, 0,
                  ((i % 4) == 3) || (((i % 4) == 1) && (i >= 5)));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_state("tr_rst", 0, 0, 0, 0);
    chk("tr_rst phase", 32'(dut.u_acc.phase), 32'd0);

    // Degenerate config: step=0, dwell=0, stop below start
    launch(2'd0, 5, 3, 0, 0);
    check_state("bd0", 5, 1, 0, 0);
    phase_m = 5;
    tick();
    check_state("bd_done", 0, 0, 1, 0);

    // Abort while freq=32
    launch(2'd0, 16, 64, 16, 2);
    phase_m = 16;
    tick();
    phase_m = 32;
    tick();
    check_state("ab_f32", 32, 1, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_state("ab_stop", 0, 0, 0, 0);
    tick();
    check_state("ab_after", 0, 0, 0, 0);

    // Start and abort together from idle
    mode = 2'd1; f_start = 12'd8; f_stop = 12'd24; f_step = 12'd8; dwell = 8'd1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_state("sa_same", 0, 0, 0, 0);
    tick();
    check_state("sa_after", 0, 0, 0, 0);

    // High frequency held for a long dwell: exercises sq_out and wave_out
    launch(2'd3, 4000, 4000, 1, 20);
    check_state("hf0", 4000, 1, 0, 0);
    for (int i = 1; i < 20; i++) begin
      phase_m = (phase_m + 4000) & 16'hFFFF;
      tick();
      check_state($sformatf("hf%0d", i), 4000, 1, 0, 0);
    end
    tick();
    check_state("hf_done", 0, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
